// File: rtl/coriolis_fpdiv_share_arb.sv
// Shares one pipelined, stallable FloPoCo FP divider between NREQ lanes, round-robin.
// Define CORIOLIS_FPDIV_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module coriolis_fpdiv_share_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 34,
  parameter int unsigned LATENCY = 13,
  parameter int unsigned IDW     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_x,
  input  logic [NREQ*DW-1:0] req_y,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    res_valid,
  output logic [DW-1:0]      res_data,
  input  logic [NREQ-1:0]    res_ready,
  output logic [DW-1:0]      div_x,
  output logic [DW-1:0]      div_y,
  output logic               div_stall,
  input  logic [DW-1:0]      div_r,
  output logic               busy
);

  logic           tag_v  [LATENCY];
  logic [IDW-1:0] tag_id [LATENCY];
  logic           head_v;
  logic [IDW-1:0] head_id;
  logic           advance;
  logic           gnt_v;
  logic [IDW-1:0] gnt_id;
  logic           issue;

`ifndef CORIOLIS_FPDIV_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] rr_ptr;
`endif

  assign head_v  = tag_v[LATENCY-1];
  assign head_id = tag_id[LATENCY-1];

  always_comb begin : head_retire
    advance   = ~head_v;
    res_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (head_id == IDW'(i)) begin
        if (res_ready[i]) advance = 1'b1;
        res_valid[i] = head_v & ~rst;
      end
    end
  end

  assign div_stall = ~rst & ~advance;
  assign res_data  = div_r;

  // Scan order starts one past the last winner; fixed build always starts at lane 0.
  always_comb begin : grant_scan
    int unsigned base;
`ifdef CORIOLIS_FPDIV_ARB_FIXED_PRIO_EN
    base = NREQ - 1;
`else
    base = 32'(rr_ptr);
`endif
    gnt_v  = 1'b0;
    gnt_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_v && req_valid[i] && (i == (base + 1 + k) % NREQ)) begin
          gnt_v  = 1'b1;
          gnt_id = IDW'(i);
        end
      end
    end
  end

  assign issue = ~rst & advance & gnt_v;

  always_comb begin : issue_mux
    req_ready = '0;
    div_x     = '0;
    div_y     = '0;
    if (issue) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt_id == IDW'(i)) begin
          req_ready[i] = 1'b1;
          div_x        = req_x[i*DW +: DW];
          div_y        = req_y[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < LATENCY; j++) begin
        tag_v[j]  <= 1'b0;
        tag_id[j] <= '0;
      end
`ifndef CORIOLIS_FPDIV_ARB_FIXED_PRIO_EN
      rr_ptr <= IDW'(NREQ - 1);
`endif
    end else if (advance) begin
      tag_v[0]  <= gnt_v;
      tag_id[0] <= gnt_v ? gnt_id : '0;
      for (int unsigned j = 1; j < LATENCY; j++) begin
        tag_v[j]  <= tag_v[j-1];
        tag_id[j] <= tag_id[j-1];
      end
`ifndef CORIOLIS_FPDIV_ARB_FIXED_PRIO_EN
      if (gnt_v) rr_ptr <= gnt_id;
`endif
    end
  end

  always_comb begin : busy_or
    busy = 1'b0;
    for (int unsigned j = 0; j < LATENCY; j++) busy = busy | tag_v[j];
  end

endmodule

// File: tb/tb_coriolis_fpdiv_share_arb.sv
// Directed bench for coriolis_fpdiv_share_arb with a stand-in stallable divider pipeline.
module tb_coriolis_fpdiv_share_arb;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned DW      = 34;
  localparam int unsigned LATENCY = 13;
  localparam int unsigned IDW     = 3;

  localparam logic [DW-1:0] X6 = {2'b01, 32'h40C0_0000};
  localparam logic [DW-1:0] Y3 = {2'b01, 32'h4040_0000};
  localparam logic [DW-1:0] R2 = {2'b01, 32'h4000_0000};

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ*DW-1:0] req_y;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    res_valid;
  logic [DW-1:0]      res_data;
  logic [NREQ-1:0]    res_ready;
  logic [DW-1:0]      div_x;
  logic [DW-1:0]      div_y;
  logic               div_stall;
  logic [DW-1:0]      div_r;
  logic               busy;

  logic [DW-1:0] lx [NREQ];
  logic [DW-1:0] ly [NREQ];
  logic [DW-1:0] lres [NREQ];
  logic [DW-1:0] pipe [LATENCY];
  int tests;
  int fails;

  always #5 clk = ~clk;

  coriolis_fpdiv_share_arb #(.NREQ(NREQ), .DW(DW), .LATENCY(LATENCY), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .div_x(div_x), .div_y(div_y), .div_stall(div_stall),
    .div_r(div_r), .busy(busy)
  );

  // Stand-in divider: exact for 6.0/3.0, otherwise a distinct per-operand signature.
  function automatic logic [DW-1:0] fdiv(input logic [DW-1:0] x, input logic [DW-1:0] y);
    if (x == X6 && y == Y3) return R2;
    return {2'b01, x[31:0] ^ {y[30:0], y[31]}};
  endfunction

  always @(posedge clk) begin
    if (!div_stall) begin
      pipe[0] <= fdiv(div_x, div_y);
      for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign div_r = pipe[LATENCY-1];

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*DW +: DW] = lx[i];
      req_y[i*DW +: DW] = ly[i];
    end
  end

  task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r, input logic rs);
    @(posedge clk);
    #1;
    req_valid = v;
    res_ready = r;
    rst       = rs;
    #1;
  endtask

  task automatic chk4(input string tag, input logic [NREQ-1:0] obs, input logic [NREQ-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] e;
    int n;
    tests = 0;
    fails = 0;
    for (int i = 0; i < NREQ; i++) begin
      lx[i] = {2'b01, 32'h3F80_0000 + (32'(i) << 20)};
      ly[i] = {2'b01, 32'h4000_0000 + (32'(i) << 16)};
    end
    lx[2] = X6;
    ly[2] = Y3;
    for (int i = 0; i < NREQ; i++) lres[i] = fdiv(lx[i], ly[i]);
    rst = 1'b1;
    req_valid = '0;
    res_ready = '1;

    // Reset behaviour
    cyc(4'b1111, 4'b1111, 1'b1);
    cyc(4'b1111, 4'b1111, 1'b1);
    chk4("rst_req_ready", req_ready, '0);
    chk4("rst_res_valid", res_valid, '0);
    chk1("rst_div_stall", div_stall, 1'b0);
    chkw("rst_div_x", div_x, '0);
    cyc('0, '1, 1'b0);
    chk1("reset_busy", busy, 1'b0);

    // Test 1: single lane 2, 6.0 / 3.0
    cyc(4'b0100, '1, 1'b0);
    chk4("t1_grant", req_ready, 4'b0100);
    chkw("t1_div_x", div_x, X6);
    chkw("t1_div_y", div_y, Y3);
    for (int c = 1; c < LATENCY; c++) begin
      cyc('0, '1, 1'b0);
      chk4("t1_early_res", res_valid, '0);
      if (c == 1) begin
        chk1("t1_busy", busy, 1'b1);
        chkw("t1_bubble_div_x", div_x, '0);
      end
    end
    cyc('0, '1, 1'b0);
    chk4("t1_res_valid", res_valid, 4'b0100);
    chkw("t1_res_data", res_data, R2);
    cyc('0, '1, 1'b0);
    chk1("t1_idle_busy", busy, 1'b0);
    chk4("t1_idle_res", res_valid, '0);

`ifndef CORIOLIS_FPDIV_ARB_FIXED_PRIO_EN
    // Test 4: lanes 0 and 3 with rr_ptr = 3
    cyc(4'b1000, '1, 1'b0);
    chk4("t4_set_ptr3", req_ready, 4'b1000);
    cyc(4'b1001, '1, 1'b0);
    chk4("t4_wrap_lane0", req_ready, 4'b0001);
    cyc(4'b1001, '1, 1'b0);
    chk4("t4_then_lane3", req_ready, 4'b1000);
    for (int c = 3; c < LATENCY; c++) cyc('0, '1, 1'b0);
    cyc('0, '1, 1'b0);
    chk4("t4_res0_valid", res_valid, 4'b1000);
    chkw("t4_res0_data", res_data, lres[3]);
    cyc('0, '1, 1'b0);
    chk4("t4_res1_valid", res_valid, 4'b0001);
    chkw("t4_res1_data", res_data, lres[0]);
    cyc('0, '1, 1'b0);
    chk4("t4_res2_valid", res_valid, 4'b1000);
    chkw("t4_res2_data", res_data, lres[3]);

    // Test 2: all lanes continuously valid, rr_ptr = 3
    for (int k = 0; k < 33; k++) begin
      cyc(k < 20 ? 4'b1111 : 4'b0000, '1, 1'b0);
      chk4("t2_grant", req_ready, k < 20 ? 4'(1 << (k % 4)) : 4'b0000);
      if (k >= 13) begin
        chk4("t2_res_valid", res_valid, 4'(1 << ((k - 13) % 4)));
        chkw("t2_res_data", res_data, lres[(k - 13) % 4]);
      end else begin
        chk4("t2_no_res", res_valid, '0);
      end
    end
    cyc('0, '1, 1'b0);
    chk1("t2_drained", busy, 1'b0);
`endif

    // Test 3: lane 1 head back-pressured for 5 cycles
    cyc(4'b0010, '1, 1'b0);
    chk4("t3_issue_l1", req_ready, 4'b0010);
    cyc(4'b0001, '1, 1'b0);
    chk4("t3_issue_l0", req_ready, 4'b0001);
    for (int c = 2; c < LATENCY; c++) cyc('0, '1, 1'b0);
    for (int s = 0; s < 5; s++) begin
      cyc(4'b0100, 4'b1101, 1'b0);
      chk1("t3_stall", div_stall, 1'b1);
      chk4("t3_blocked", req_ready, '0);
      chk4("t3_hold_valid", res_valid, 4'b0010);
      chkw("t3_hold_data", res_data, lres[1]);
    end
    cyc(4'b0100, '1, 1'b0);
    chk1("t3_release", div_stall, 1'b0);
    chk4("t3_release_valid", res_valid, 4'b0010);
    chk4("t3_grant_l2", req_ready, 4'b0100);
    cyc('0, '1, 1'b0);
    chk4("t3_next_valid", res_valid, 4'b0001);
    chkw("t3_next_data", res_data, lres[0]);
    for (int c = 2; c < LATENCY; c++) cyc('0, '1, 1'b0);
    cyc('0, '1, 1'b0);
    chk4("t3_l2_valid", res_valid, 4'b0100);
    chkw("t3_l2_data", res_data, lres[2]);

    // Test 5: reset with 7 in flight
    for (int k = 0; k < 7; k++) begin
`ifdef CORIOLIS_FPDIV_ARB_FIXED_PRIO_EN
      e = 4'b0001;
`else
      e = 4'(1 << ((3 + k) % 4));
`endif
      cyc(4'b1111, '1, 1'b0);
      chk4("t5_fill", req_ready, e);
    end
    cyc(4'b1111, '1, 1'b1);
    chk4("t5_rst_ready", req_ready, '0);
    chk1("t5_rst_stall", div_stall, 1'b0);
    chkw("t5_rst_div_y", div_y, '0);
    cyc('0, '1, 1'b0);
    chk1("t5_busy_cleared", busy, 1'b0);
    for (int c = 0; c < 15; c++) begin
      cyc('0, '1, 1'b0);
      chk4("t5_no_res", res_valid, '0);
    end
    cyc(4'b1111, '1, 1'b0);
    chk4("t5_first_after_rst", req_ready, 4'b0001);

    // Test 6: lanes 0 and 2 always valid
    for (int k = 0; k < 6; k++) begin
`ifdef CORIOLIS_FPDIV_ARB_FIXED_PRIO_EN
      e = 4'b0001;
`else
      e = (k % 2 == 0) ? 4'b0100 : 4'b0001;
`endif
      cyc(4'b0101, '1, 1'b0);
      chk4("t6_grant", req_ready, e);
    end

    n = 0;
    cyc('0, '1, 1'b0);
    while (busy && n < 40) begin
      cyc('0, '1, 1'b0);
      n++;
    end
    chk1("final_drain", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
